// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, LSB first) with a small byte FIFO on a valid/ready output stream.
// Latency: 2-cycle synchroniser; byte pushed at mid-stop-bit; m_valid rises the cycle after the push.
// Backpressure: m_ready low holds the FIFO head; a good byte arriving at a full FIFO with no pop is dropped and flagged.
//
// Ports:
//   clk_12p0   system clock
//   rst_n      asynchronous active-low reset
//   rx_in      raw asynchronous UART line, idles high
//   m_data     byte at FIFO head (0 when empty)
//   m_valid    FIFO non-empty
//   m_ready    consumer accept; a pop happens when m_valid & m_ready
//   frame_err  one-cycle pulse when the stop bit samples as 0
//   overrun    one-cycle pulse when a good byte is dropped on a full FIFO
//   fifo_count number of bytes currently stored
module uart_rx_fifo #(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_12p0,
  input  logic                          rst_n,
  input  logic                          rx_in,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_F        = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_F-1:0] DEPTH_C  = CNT_F'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Line synchroniser; resets to the idle (high) level so reset never looks
  // like a start bit.
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge clk_12p0 or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  logic half_tick;
  logic bit_tick;
  logic cnt_run;
  logic cnt_clr;
  logic idx_clr;
  logic sample_bit;
  logic push;
  logic stop_bad;

  assign half_tick = (baud_cnt == HALF_END);
  assign bit_tick  = (baud_cnt == BIT_END);

  always_ff @(posedge clk_12p0 or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!rx_s)     state_nxt = S_START;
      // A start bit that is high again at its midpoint was a glitch.
      S_START: if (half_tick) state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (bit_tick && bit_idx == 3'd7) state_nxt = S_STOP;
      S_STOP:  if (bit_tick)  state_nxt = rx_s ? S_IDLE : S_BREAK;
      // Hold off during a line break until the line returns high.
      S_BREAK: if (rx_s)      state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_run    = 1'b0;
    cnt_clr    = 1'b0;
    idx_clr    = 1'b0;
    sample_bit = 1'b0;
    push       = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      S_START: begin
        cnt_run = 1'b1;
        cnt_clr = half_tick;
        idx_clr = half_tick;
      end
      S_DATA: begin
        cnt_run    = 1'b1;
        cnt_clr    = bit_tick;
        sample_bit = bit_tick;
      end
      S_STOP: begin
        cnt_run  = 1'b1;
        cnt_clr  = bit_tick;
        push     = bit_tick & rx_s;
        stop_bad = bit_tick & ~rx_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_12p0 or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      if (!cnt_run || cnt_clr) baud_cnt <= '0;
      else                     baud_cnt <= baud_cnt + CNT_W'(1);

      if (idx_clr)         bit_idx <= '0;
      else if (sample_bit) bit_idx <= bit_idx + 3'd1;

      // Right shift: after 8 LSB-first samples the first bit sits in bit 0.
      if (sample_bit) shreg <= {rx_s, shreg[7:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_F-1:0] count;
  logic             full;
  logic             pop;
  logic             push_ok;

  assign full    = (count == DEPTH_C);
  assign m_valid = (count != '0);
  assign pop     = m_valid & m_ready;
  // A simultaneous pop frees the slot the push needs.
  assign push_ok = push & (~full | pop);

  assign m_data     = m_valid ? mem[rd_ptr] : 8'h00;
  assign fifo_count = count;

  always_ff @(posedge clk_12p0) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk_12p0 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // Pointers wrap naturally since the depth is a power of two.
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_F'(1);
        2'b01:   count <= count - CNT_F'(1);
        default: count <= count;
      endcase
      frame_err <= stop_bad;
      overrun   <= push & full & ~pop;
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver for the ICE_27 input pin. Feeds received bytes into the pipelinec_top logic through a valid/ready stream.
- Synchronises the asynchronous line, detects the start bit and samples each bit at mid-bit (8N1, LSB first).
- Received bytes are buffered in a small FIFO, so the consuming pipeline may stall briefly without losing data.

Parameters:
- CLK_HZ, 12000000, clock frequency in Hz.
- BAUD, 115200, line rate in bits per second.
- FIFO_DEPTH, 4, byte FIFO depth. Must be a power of two and at least 2.
- Derived: CLKS_PER_BIT = CLK_HZ/BAUD, integer-truncated (104 at defaults); HALF_BIT = CLKS_PER_BIT/2 (52).

Ports:
- clk_12p0  in  1  system clock, 12 MHz board oscillator.
- rst_n  in  1  asynchronous, active-low reset.
- rx_in  in  1  raw UART line from the ICE_27 pin; asynchronous; idles high.
- m_data  out  8  byte at the FIFO head.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts m_data when m_valid and m_ready are both 1 in the same cycle.
- frame_err  out  1  one-cycle pulse when a stop bit is sampled as 0.
- overrun  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of bytes currently stored.

Behaviour:
- Reset (clk_12p0 domain, asynchronous assert on rst_n low):
  - Synchroniser flops reset to 1; FSM goes to IDLE; bit counter, baud counter and shift register clear.
  - FIFO empties. m_valid=0, m_data=0, frame_err=0, overrun=0, fifo_count=0.
  - Asserting rst_n mid-frame aborts the frame; no partial byte is ever pushed.
- Synchroniser:
  - Two flops on rx_in, giving 2 cycles of latency. The FSM uses only the synchronised value, rx_s.
- FSM states:
  - IDLE: when rx_s==0, clear baud_cnt and go to START.
  - START: when baud_cnt==HALF_BIT-1, sample rx_s. If 1, treat as a glitch and return to IDLE. If 0, clear baud_cnt and bit_idx and go to DATA.
  - DATA: when baud_cnt==CLKS_PER_BIT-1, shift rx_s into bit 7 of the shift register (right shift, so LSB-first data lands correctly), clear baud_cnt and increment bit_idx. After the 8th sample go to STOP.
  - STOP: when baud_cnt==CLKS_PER_BIT-1, sample rx_s.
    - If 1: issue a push request with the shift register contents and go to IDLE. This happens at mid-stop-bit, so a start bit that immediately follows is caught.
    - If 0: pulse frame_err for 1 cycle, discard the byte and go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. This prevents false starts during a line break.
- Counters:
  - baud_cnt is wide enough for CLKS_PER_BIT-1.
  - baud_cnt increments every cycle in START, DATA and STOP, and holds at 0 in IDLE and BREAK.
- Timing:
  - From the first rx_s low cycle, the stop-bit sample occurs HALF_BIT + 9*CLKS_PER_BIT cycles later (988 at defaults).
  - m_valid rises the cycle after the push request when the FIFO was empty.
- FIFO:
  - Circular buffer with read and write pointers and a count register.
  - pop = m_valid & m_ready.
  - A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - A push into a full FIFO with no pop drops the byte, pulses overrun for 1 cycle, and leaves the existing contents unchanged.
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
  - m_data is the head entry registered/read directly; it is stable while m_valid=1 and m_ready=0.
- frame_err and overrun never assert in the same cycle, because the two outcomes are mutually exclusive in STOP.
- m_data and m_valid must not depend combinationally on m_ready.

Test Plan:
- Send 0xA5 at 115200 (104 clk/bit), m_ready=1 -> exactly one cycle with m_valid=1 and m_data=0xA5, arriving about 990 cycles after the falling edge; frame_err=0 and overrun=0 throughout.
- Pulse rx_in low for 20 cycles, then hold it high -> FSM returns to IDLE at the START sample; no m_valid and no frame_err.
- Send 0x3C with the stop bit forced to 0, then hold the line low for 300 cycles, then high, then send 0x11 -> one frame_err pulse; 0x3C is never output; no spurious start during the low period; 0x11 is delivered correctly.
- With m_ready=0, send 0x01..0x05 back-to-back -> fifo_count reaches 4, one overrun pulse on the 5th byte. Then set m_ready=1 -> outputs 0x01, 0x02, 0x03, 0x04 in order, and fifo_count returns to 0.
- Back-to-back frames with zero idle gap (stop bit immediately followed by start), 16 random bytes, m_ready randomly toggled with at most 3 bytes outstanding -> all bytes delivered in order, no errors.
- Assert rst_n=0 for 3 cycles in the middle of DATA for byte 0xFF, then deliver a clean 0x5A -> outputs at 0 during reset; only 0x5A is ever delivered.
